// File: rtl/regwr_sched_pkg.sv
// -----------------------------------------------------------------------------
// regwr_sched_pkg
// Shared definitions for the register-file write-port scheduler:
//   - default widths/depth used as parameter defaults by regwr_sched
//   - return-queue entry field widths (address + data payload, 1-bit live tag)
//   - write-port source selection encoding
// -----------------------------------------------------------------------------
package regwr_sched_pkg;

    localparam int DEF_FULLW  = 32;  // register data width
    localparam int DEF_REGAW  = 4;   // register address width
    localparam int DEF_QDEPTH = 2;   // load-return queue depth

    // Return-queue entry layout: {wa, wd} payload plus a separate live tag.
    localparam int RQ_LIVE_W = 1;

    function automatic int rq_data_w(input int fullw, input int regaw);
        return fullw + regaw;
    endfunction

    // Which source owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        WSEL_IDLE = 2'd0,  // nothing to write
        WSEL_WB   = 2'd1,  // in-order WB write (fixed priority)
        WSEL_LR   = 2'd2,  // pop queue head and write it
        WSEL_DROP = 2'd3   // pop a stale queue head without writing
    } wsel_e;

endpackage

// File: rtl/regwr_sched_rq_fifo.sv
// -----------------------------------------------------------------------------
// rq_fifo
// Synchronous FIFO for load returns. Each entry carries a DW-bit payload and a
// 1-bit live tag. Pointers/count use an async active-low reset; the storage
// array is data-only and is never reset.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset (empties the FIFO)
//   push_i  : write data_i/live_i at the tail (ignored when full)
//   pop_i   : drop the head entry (ignored when empty)
//   data_i  : payload to push
//   live_i  : live tag to push
//   data_o  : head payload
//   live_o  : head live tag
//   full_o  : FIFO holds DEPTH entries
//   empty_o : FIFO holds no entries
// -----------------------------------------------------------------------------
module rq_fifo
    import regwr_sched_pkg::*;
#(
    parameter int DW    = 36,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] data_i,
    input  logic          live_i,
    output logic [DW-1:0] data_o,
    output logic          live_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW:0]          cnt_q, cnt_d;
    logic [DW-1:0]        data_mem_q [DEPTH];
    logic [RQ_LIVE_W-1:0] live_mem_q [DEPTH];
    logic                 do_push, do_pop;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = data_mem_q[rd_ptr_q];
    assign live_o  = live_mem_q[rd_ptr_q][0];

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            data_mem_q[wr_ptr_q] <= data_i;
            live_mem_q[wr_ptr_q] <= RQ_LIVE_W'(live_i);
        end
    end

endmodule

// File: rtl/regwr_sched.sv
// -----------------------------------------------------------------------------
// regwr_sched
// Shares the single register-file write port between the in-order WB stage
// (fixed priority, never back-pressured) and the long-latency load return path
// (valid/ready, buffered in a small FIFO). A per-register scoreboard tracks
// outstanding load destinations and marks returns that a younger WB write has
// overtaken so they complete their handshake without writing.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   wb_we/wb_wa/wb_wd   : WB-stage write request
//   iss_valid/iss_rd    : long-latency load issue and its destination
//   lr_valid/lr_wa/lr_wd: load return request
//   lr_ready            : return queue can accept (not full)
//   rf_we/rf_wa/rf_wd   : registered register-file write port
//   busy                : outstanding long-latency destinations
//   stall_req           : queue full with a return waiting; WB must bubble
// -----------------------------------------------------------------------------
module regwr_sched
    import regwr_sched_pkg::*;
#(
    parameter int FULLW  = DEF_FULLW,
    parameter int REGAW  = DEF_REGAW,
    parameter int QDEPTH = DEF_QDEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wb_we,
    input  logic [REGAW-1:0]   wb_wa,
    input  logic [FULLW-1:0]   wb_wd,
    input  logic               iss_valid,
    input  logic [REGAW-1:0]   iss_rd,
    input  logic               lr_valid,
    input  logic [REGAW-1:0]   lr_wa,
    input  logic [FULLW-1:0]   lr_wd,
    output logic               lr_ready,
    output logic               rf_we,
    output logic [REGAW-1:0]   rf_wa,
    output logic [FULLW-1:0]   rf_wd,
    output logic [2**REGAW-1:0] busy,
    output logic               stall_req
);

    localparam int NREG  = 2**REGAW;
    localparam int RQ_DW = rq_data_w(FULLW, REGAW);

    logic             q_push, q_pop, q_full, q_empty, q_live, push_live;
    logic [RQ_DW-1:0] q_data;
    wsel_e            wsel;

    logic [NREG-1:0]  busy_q, busy_d;
    logic [NREG-1:0]  stale_q, stale_d;
    logic             rf_we_q, rf_we_d;
    logic [REGAW-1:0] rf_wa_q, rf_wa_d;
    logic [FULLW-1:0] rf_wd_q, rf_wd_d;

    // lr_ready depends on queue state only, never on lr_valid.
    assign lr_ready  = !q_full;
    assign q_push    = lr_valid && !q_full;
    assign stall_req = q_full && lr_valid;

    // A WB write in the same cycle as the push counts as overtaking the load.
    assign push_live = !(stale_q[lr_wa] || (wb_we && (wb_wa == lr_wa)));

    rq_fifo #(
        .DW    (RQ_DW),
        .DEPTH (QDEPTH)
    ) u_rq_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .data_i  ({lr_wa, lr_wd}),
        .live_i  (push_live),
        .data_o  (q_data),
        .live_o  (q_live),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    // Port arbitration: WB always wins; otherwise drain the queue head.
    always_comb begin
        wsel = WSEL_IDLE;
        if (wb_we) begin
            wsel = WSEL_WB;
        end else if (!q_empty) begin
            wsel = q_live ? WSEL_LR : WSEL_DROP;
        end
    end

    assign q_pop = (wsel == WSEL_LR) || (wsel == WSEL_DROP);

    always_comb begin
        rf_we_d = 1'b0;
        rf_wa_d = rf_wa_q;
        rf_wd_d = rf_wd_q;
        case (wsel)
            WSEL_WB: begin
                rf_we_d = 1'b1;
                rf_wa_d = wb_wa;
                rf_wd_d = wb_wd;
            end
            WSEL_LR: begin
                rf_we_d = 1'b1;
                {rf_wa_d, rf_wd_d} = q_data;
            end
            default: rf_we_d = 1'b0;
        endcase
    end

    // Scoreboard update order matters: WB marking, then push retire, then a
    // new issue, so a same-cycle issue/push to one register leaves it busy
    // and not stale.
    always_comb begin
        busy_d  = busy_q;
        stale_d = stale_q;
        if (wb_we && busy_q[wb_wa]) begin
            stale_d[wb_wa] = 1'b1;
        end
        if (q_push) begin
            busy_d[lr_wa] = 1'b0;
        end
        if (iss_valid) begin
            busy_d[iss_rd]  = 1'b1;
            stale_d[iss_rd] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            stale_q <= '0;
            rf_we_q <= 1'b0;
            rf_wa_q <= '0;
            rf_wd_q <= '0;
        end else begin
            busy_q  <= busy_d;
            stale_q <= stale_d;
            rf_we_q <= rf_we_d;
            rf_wa_q <= rf_wa_d;
            rf_wd_q <= rf_wd_d;
        end
    end

    assign busy  = busy_q;
    assign rf_we = rf_we_q;
    assign rf_wa = rf_wa_q;
    assign rf_wd = rf_wd_q;

endmodule
